// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel-tick divider, h/v counters and porch/sync phase FSMs.
// Define VGA_SYNC_ALIGN_EN to delay hsync_out/vsync_out by one extra clk.
module vga_timing_gen #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       clk_in,
    input  logic       rst_n_in,
    output logic       pixel_tick,
    output logic [9:0] current_row,
    output logic [9:0] current_line,
    output logic       enable,
    output logic       hsync_out,
    output logic       vsync_out,
    output logic       line_start,
    output logic       frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    localparam logic [9:0] H_ACT_END  = 10'(H_ACTIVE - 1);
    localparam logic [9:0] H_FP_END   = 10'(H_ACTIVE + H_FP - 1);
    localparam logic [9:0] H_SYNC_END = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_ACT_END  = 10'(V_ACTIVE - 1);
    localparam logic [9:0] V_FP_END   = 10'(V_ACTIVE + V_FP - 1);
    localparam logic [9:0] V_SYNC_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);

    typedef enum logic [1:0] {PH_ACTIVE, PH_FP, PH_SYNC, PH_BP} phase_t;

    logic [DIV_W-1:0] div_cnt;
    logic             started;
    logic             advance;
    logic             h_wrap;
    logic             v_wrap;
    logic [9:0]       h_cnt_nxt;
    logic [9:0]       v_cnt_nxt;
    phase_t           h_state, h_state_nxt;
    phase_t           v_state, v_state_nxt;
    logic             hsync_p0;
    logic             vsync_p0;

    function automatic phase_t phase_step(input phase_t ph, input logic [9:0] cnt,
                                          input logic [9:0] act_end, input logic [9:0] fp_end,
                                          input logic [9:0] sync_end, input logic [9:0] last);
        phase_step = ph;
        case (ph)
            PH_ACTIVE: if (cnt == act_end)  phase_step = PH_FP;
            PH_FP:     if (cnt == fp_end)   phase_step = PH_SYNC;
            PH_SYNC:   if (cnt == sync_end) phase_step = PH_BP;
            PH_BP:     if (cnt == last)     phase_step = PH_ACTIVE;
            default:                        phase_step = PH_ACTIVE;
        endcase
    endfunction

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            div_cnt    <= '0;
            pixel_tick <= 1'b0;
        end else begin
            div_cnt    <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
            pixel_tick <= (div_cnt == DIV_LAST);
        end
    end

    // The first tick after reset only starts pixel (0,0); later ticks step the raster.
    assign advance = pixel_tick && started;
    assign h_wrap  = (current_row == H_LAST);
    assign v_wrap  = (current_line == V_LAST);

    always_comb begin
        h_cnt_nxt   = current_row;
        v_cnt_nxt   = current_line;
        h_state_nxt = h_state;
        v_state_nxt = v_state;
        if (advance) begin
            h_cnt_nxt   = h_wrap ? 10'd0 : current_row + 10'd1;
            h_state_nxt = phase_step(h_state, current_row, H_ACT_END, H_FP_END, H_SYNC_END, H_LAST);
            if (h_wrap) begin
                v_cnt_nxt   = v_wrap ? 10'd0 : current_line + 10'd1;
                v_state_nxt = phase_step(v_state, current_line, V_ACT_END, V_FP_END, V_SYNC_END, V_LAST);
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            started      <= 1'b0;
            current_row  <= 10'd0;
            current_line <= 10'd0;
            h_state      <= PH_ACTIVE;
            v_state      <= PH_ACTIVE;
            enable       <= 1'b0;
            hsync_p0     <= 1'b1;
            vsync_p0     <= 1'b1;
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
        end else begin
            line_start  <= advance && h_wrap;
            frame_start <= advance && h_wrap && v_wrap;
            if (pixel_tick) begin
                started      <= 1'b1;
                current_row  <= h_cnt_nxt;
                current_line <= v_cnt_nxt;
                h_state      <= h_state_nxt;
                v_state      <= v_state_nxt;
                enable       <= (h_state_nxt == PH_ACTIVE) && (v_state_nxt == PH_ACTIVE);
                hsync_p0     <= (h_state_nxt != PH_SYNC);
                vsync_p0     <= (v_state_nxt != PH_SYNC);
            end
        end
    end

`ifdef VGA_SYNC_ALIGN_EN
    // Extra stage lines sync up with the registered colour output downstream.
    logic hsync_p1;
    logic vsync_p1;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            hsync_p1 <= 1'b1;
            vsync_p1 <= 1'b1;
        end else begin
            hsync_p1 <= hsync_p0;
            vsync_p1 <= vsync_p0;
        end
    end

    assign hsync_out = hsync_p1;
    assign vsync_out = vsync_p1;
`else
    assign hsync_out = hsync_p0;
    assign vsync_out = vsync_p0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default-timing instance for divider/line checks, a shrunken
// instance (CLK_DIV=1, 13x8 raster) for frame, vsync and wrap checks.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

`ifdef VGA_SYNC_ALIGN_EN
    localparam int SYNC_LAT = 1;
`else
    localparam int SYNC_LAT = 0;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic       a_tick, a_en, a_hs, a_vs, a_ls, a_fs;
    logic [9:0] a_row, a_line;
    logic       b_tick, b_en, b_hs, b_vs, b_ls, b_fs;
    logic [9:0] b_row, b_line;

    vga_timing_gen dut_a (
        .clk_in(clk), .rst_n_in(rst_n), .pixel_tick(a_tick),
        .current_row(a_row), .current_line(a_line), .enable(a_en),
        .hsync_out(a_hs), .vsync_out(a_vs), .line_start(a_ls), .frame_start(a_fs)
    );

    vga_timing_gen #(
        .CLK_DIV(1), .H_ACTIVE(6), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) dut_b (
        .clk_in(clk), .rst_n_in(rst_n), .pixel_tick(b_tick),
        .current_row(b_row), .current_line(b_line), .enable(b_en),
        .hsync_out(b_hs), .vsync_out(b_vs), .line_start(b_ls), .frame_start(b_fs)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic reset_checks();
        chk("a_rst_tick", a_tick, 0);
        chk("a_rst_row", a_row, 0);
        chk("a_rst_line", a_line, 0);
        chk("a_rst_en", a_en, 0);
        chk("a_rst_hs", a_hs, 1);
        chk("a_rst_vs", a_vs, 1);
        chk("a_rst_ls", a_ls, 0);
        chk("a_rst_fs", a_fs, 0);
        chk("b_rst_tick", b_tick, 0);
        chk("b_rst_row", b_row, 0);
        chk("b_rst_en", b_en, 0);
        chk("b_rst_hs", b_hs, 1);
    endtask

    task automatic startup_checks();
        step(1);
        chk("a_tick_e1", a_tick, 0);
        chk("b_tick_e1", b_tick, 1);
        chk("b_en_e1", b_en, 0);
        step(1);
        chk("a_tick_e2", a_tick, 0);
        chk("b_tick_e2", b_tick, 1);
        chk("b_en_e2", b_en, 1);
        chk("b_row_e2", b_row, 0);
        chk("b_ls_e2", b_ls, 0);
        chk("b_fs_e2", b_fs, 0);
        step(1);
        chk("a_tick_e3", a_tick, 0);
        chk("b_row_e3", b_row, 1);
        step(1);
        chk("a_tick_e4", a_tick, 1);
        chk("a_en_e4", a_en, 0);
        step(1);
        chk("a_tick_e5", a_tick, 0);
        chk("a_en_e5", a_en, 1);
        chk("a_row_e5", a_row, 0);
        chk("a_ls_e5", a_ls, 0);
        chk("a_fs_e5", a_fs, 0);
        chk("a_hs_e5", a_hs, 1);
        step(3);
        chk("a_tick_e8", a_tick, 1);
        chk("a_row_e8", a_row, 0);
        step(1);
        chk("a_row_e9", a_row, 1);
        chk("a_tick_e9", a_tick, 0);
    endtask

    int   ev_cyc[2];
    int   ev_n, hs_low, vs_low, en_hi, viol, fall_at, max_row, max_line, fs_cnt, vs_cnt;
    int   prev_row, prev_line;
    logic prev_s;

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_checks();
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        startup_checks();

        // Small instance: two frame_starts, vsync and wrap behaviour
        ev_n = 0; hs_low = 0; vs_low = 0; en_hi = 0; viol = 0;
        fall_at = -1; max_row = 0; max_line = 0; prev_s = 1'b1;
        for (int i = 0; i < 400 && ev_n < 2; i++) begin
            prev_row  = int'(b_row);
            prev_line = int'(b_line);
            step(1);
            if (int'(b_row) > max_row) max_row = int'(b_row);
            if (int'(b_line) > max_line) max_line = int'(b_line);
            if (b_en && (b_row >= 10'd6 || b_line >= 10'd4)) viol++;
            if (b_fs) begin
                ev_cyc[ev_n] = cyc;
                ev_n++;
                if (ev_n == 1) begin
                    chk("b_wrap_prev_row", prev_row, 12);
                    chk("b_wrap_prev_line", prev_line, 7);
                    chk("b_wrap_row", b_row, 0);
                    chk("b_wrap_line", b_line, 0);
                    chk("b_wrap_ls", b_ls, 1);
                end
            end
            if (ev_n == 1) begin
                if (!b_vs) vs_low++;
                if (!b_hs) hs_low++;
                if (b_en) en_hi++;
                if (!b_vs && prev_s && fall_at < 0) fall_at = int'(b_line);
            end
            prev_s = b_vs;
        end
        chk("b_fs_seen", ev_n, 2);
        chk("b_first_fs_cyc", ev_cyc[0], 106);
        chk("b_frame_period", ev_cyc[1] - ev_cyc[0], 104);
        chk("b_vs_low_clks", vs_low, 26);
        chk("b_hs_low_clks", hs_low, 24);
        chk("b_en_clks", en_hi, 24);
        chk("b_vs_fall_line", fall_at, 5);
        chk("b_en_outside", viol, 0);
        chk("b_max_row", max_row, 12);
        chk("b_max_line", max_line, 7);

        // Default instance: one full line between two line_starts
        ev_n = 0; hs_low = 0; en_hi = 0; viol = 0; fall_at = -1;
        max_row = 0; fs_cnt = 0; vs_cnt = 0; prev_s = 1'b1;
        for (int i = 0; i < 7000 && ev_n < 2; i++) begin
            step(1);
            if (int'(a_row) > max_row) max_row = int'(a_row);
            if (a_en && a_row >= 10'd640) viol++;
            if (a_fs) fs_cnt++;
            if (!a_vs) vs_cnt++;
            if (a_ls) begin
                ev_cyc[ev_n] = cyc;
                ev_n++;
            end
            if (ev_n == 1) begin
                if (!a_hs) hs_low++;
                if (a_en) en_hi++;
                if (!a_hs && prev_s && fall_at < 0) fall_at = cyc - ev_cyc[0];
            end
            prev_s = a_hs;
        end
        chk("a_ls_seen", ev_n, 2);
        chk("a_first_ls_cyc", ev_cyc[0], 3205);
        chk("a_line_period", ev_cyc[1] - ev_cyc[0], 3200);
        chk("a_hs_low_clks", hs_low, 384);
        chk("a_hs_fall_offset", fall_at, 2624 + SYNC_LAT);
        chk("a_en_clks", en_hi, 2560);
        chk("a_en_outside", viol, 0);
        chk("a_max_row", max_row, 799);
        chk("a_no_fs", fs_cnt, 0);
        chk("a_no_vsync", vs_cnt, 0);
        chk("a_line_after", a_line, 2);

        // Mid-frame reset pulse, then the startup sequence again
        for (int i = 0; i < 2000 && a_row != 10'd300; i++) step(1);
        chk("a_reached_row", a_row, 300);
        chk("a_en_before_rst", a_en, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        reset_checks();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        startup_checks();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
